// File: rtl/clock_pkg.sv
// Shared types and constants for the clock health monitor.
package clock_pkg;

    // Exported FSM state encoding; values are visible in the register map.
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_MONITOR = 3'd1,
        ST_FAULT   = 3'd2,
        ST_RECFG   = 3'd3,
        ST_HALT    = 3'd4
    } state_e;

    // Width of the saturating lock-loss counter.
    localparam int LOCK_CNT_W = 16;

    // Nominal counts per one-second evaluation window of the 125 MHz clk,
    // used to assemble EXP_FREQ when the monitor is instantiated.
    localparam logic [31:0] FREQ_125 = 32'd125_000_000;
    localparam logic [31:0] FREQ_100 = 32'd100_000_000;
    localparam logic [31:0] FREQ_250 = 32'd250_000_000;

endpackage

// File: rtl/freq_window_check.sv
// Combinational tolerance check: |fc - exp_freq| <= tol, evaluated at 33 bits
// so that operands near 32'hFFFFFFFF cannot wrap.
module freq_window_check (
    input  logic [31:0] fc,
    input  logic [31:0] exp_freq,
    input  logic [31:0] tol,
    output logic        in_win
);

    logic [32:0] diff;
    logic [32:0] mag;

    // Signed difference, absolute value, then unsigned compare against tol.
    always_comb begin
        diff   = {1'b0, fc} - {1'b0, exp_freq};
        mag    = diff[32] ? (~diff + 33'd1) : diff;
        in_win = (mag <= {1'b0, tol});
    end

endmodule

// File: rtl/clock_health_monitor.sv
// Clock health monitor: evaluates per-channel frequency counts once per
// evaluation period, tracks LMK lock losses and drives a reconfiguration
// request/ack loop with a bounded number of retries.
module clock_health_monitor
    import clock_pkg::*;
#(
    parameter int unsigned              NUM_CH       = 4,
    parameter int unsigned              TICK_CYCLES  = 125000000,
    parameter int unsigned              SETTLE_TICKS = 2,
    parameter int unsigned              FAIL_COUNT   = 3,
    parameter int unsigned              MAX_RETRIES  = 3,
    parameter logic [NUM_CH-1:0][31:0]  EXP_FREQ     = {NUM_CH{32'd0}},
    parameter logic [NUM_CH-1:0][31:0]  TOL          = {NUM_CH{32'd0}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0][31:0]     fc_q,
    input  logic                        cc_locked,
    input  logic                        sts_clr,
    output logic [NUM_CH-1:0]           ch_ok,
    output logic [NUM_CH-1:0]           ch_alarm,
    output logic [LOCK_CNT_W-1:0]       lock_loss_cnt,
    output logic                        recfg_req,
    input  logic                        recfg_ack,
    output logic [2:0]                  state,
    output logic                        halted
);

    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int CNT_W  = 8;
    localparam int GOOD_W = 5;

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_LIM = CNT_W'(SETTLE_TICKS);
    localparam logic [CNT_W-1:0]  FAIL_LIM   = CNT_W'(FAIL_COUNT);
    localparam logic [CNT_W-1:0]  RETRY_LIM  = CNT_W'(MAX_RETRIES);
    // Sixteen consecutive good evaluations forgive earlier retries.
    localparam logic [GOOD_W-1:0] GOOD_LAST  = GOOD_W'(15);

    state_e                  state_q, state_d;
    logic [2:0]              sync_q, sync_d;
    logic [TICK_W-1:0]       tick_cnt_q, tick_cnt_d;
    logic [CNT_W-1:0]        settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]        fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0]        retry_cnt_q, retry_cnt_d;
    logic [GOOD_W-1:0]       good_cnt_q, good_cnt_d;
    logic [NUM_CH-1:0]       ch_ok_q, ch_ok_d;
    logic [NUM_CH-1:0]       ch_alarm_q, ch_alarm_d;
    logic [LOCK_CNT_W-1:0]   lock_loss_q, lock_loss_d;
    logic                    recfg_req_q, recfg_req_d;
    logic                    halted_q, halted_d;

    logic [NUM_CH-1:0]       in_win;
    logic [NUM_CH-1:0]       alarm_set;
    logic                    tick;
    logic                    sync_locked;
    logic                    lock_fall;
    logic                    all_ok;

    // One window checker per monitored clock.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_chk
            freq_window_check u_chk (
                .fc       (fc_q[gi]),
                .exp_freq (EXP_FREQ[gi]),
                .tol      (TOL[gi]),
                .in_win   (in_win[gi])
            );
        end
    endgenerate

    // Lock synchroniser shift, lock edge detect on the last two stages, and tick decode.
    always_comb begin
        sync_d      = {sync_q[1:0], cc_locked};
        sync_locked = sync_q[1];
        lock_fall   = sync_q[2] & ~sync_q[1];
        tick        = (tick_cnt_q == TICK_LAST);
        all_ok      = (&in_win) & sync_locked;
    end

    // FSM next state plus the settle/fail/retry/good counters it owns.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        retry_cnt_d  = retry_cnt_q;
        good_cnt_d   = good_cnt_q;
        alarm_set    = '0;
        case (state_q)
            ST_INIT: begin
                good_cnt_d = '0;
                if (tick) begin
                    if (settle_cnt_q + 8'd1 >= SETTLE_LIM) begin
                        state_d      = ST_MONITOR;
                        settle_cnt_d = '0;
                        fail_cnt_d   = '0;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 8'd1;
                    end
                end
            end
            ST_MONITOR: begin
                if (tick) begin
                    alarm_set = ~in_win;
                end
                if (fail_cnt_q >= FAIL_LIM) begin
                    state_d    = ST_FAULT;
                    fail_cnt_d = '0;
                    good_cnt_d = '0;
                end else if (lock_fall) begin
                    // A lost lock is treated as an immediate persistent fault.
                    fail_cnt_d = FAIL_LIM;
                    good_cnt_d = '0;
                end else if (tick) begin
                    if (!all_ok) begin
                        fail_cnt_d = fail_cnt_q + 8'd1;
                        good_cnt_d = '0;
                    end else begin
                        fail_cnt_d = '0;
                        if (good_cnt_q == GOOD_LAST) begin
                            good_cnt_d  = '0;
                            retry_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_cnt_q + 5'd1;
                        end
                    end
                end
            end
            ST_FAULT: begin
                if (retry_cnt_q == RETRY_LIM) begin
                    state_d = ST_HALT;
                end else begin
                    retry_cnt_d = retry_cnt_q + 8'd1;
                    state_d     = ST_RECFG;
                end
            end
            ST_RECFG: begin
                if (recfg_ack) begin
                    state_d = ST_INIT;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Tick counter wraps each period and restarts whenever a new state is entered.
    always_comb begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        if (state_d != state_q) begin
            tick_cnt_d = '0;
        end
    end

    // Status: last evaluation, sticky alarms (set beats clear), lock-loss counter (clear then count).
    always_comb begin
        ch_ok_d     = tick ? in_win : ch_ok_q;
        ch_alarm_d  = (sts_clr ? '0 : ch_alarm_q) | alarm_set;
        lock_loss_d = lock_loss_q;
        if (sts_clr) begin
            lock_loss_d = lock_fall ? LOCK_CNT_W'(1) : '0;
        end else if (lock_fall && (lock_loss_q != '1)) begin
            lock_loss_d = lock_loss_q + LOCK_CNT_W'(1);
        end
        recfg_req_d = (state_d == ST_RECFG);
        halted_d    = (state_d == ST_HALT);
    end

    // State and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sync_q       <= '0;
            tick_cnt_q   <= '0;
            settle_cnt_q <= '0;
            fail_cnt_q   <= '0;
            retry_cnt_q  <= '0;
            good_cnt_q   <= '0;
            ch_ok_q      <= '0;
            ch_alarm_q   <= '0;
            lock_loss_q  <= '0;
            recfg_req_q  <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            tick_cnt_q   <= tick_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            retry_cnt_q  <= retry_cnt_d;
            good_cnt_q   <= good_cnt_d;
            ch_ok_q      <= ch_ok_d;
            ch_alarm_q   <= ch_alarm_d;
            lock_loss_q  <= lock_loss_d;
            recfg_req_q  <= recfg_req_d;
            halted_q     <= halted_d;
        end
    end

    assign state         = state_q;
    assign ch_ok         = ch_ok_q;
    assign ch_alarm      = ch_alarm_q;
    assign lock_loss_cnt = lock_loss_q;
    assign recfg_req     = recfg_req_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_clock_health_monitor.sv
// Self-checking bench for clock_health_monitor: directed scenarios plus a
// randomized run compared against a tick-level behavioural model.
module tb_clock_health_monitor;

    localparam int NCH         = 4;
    localparam int TICK        = 100;
    localparam int MAX_RETRIES = 2;
    localparam logic [NCH-1:0][31:0] EXP_P  = {32'd50, 32'd250, 32'd125, 32'd100};
    localparam logic [NCH-1:0][31:0] TOL_P  = {32'd2, 32'd2, 32'd2, 32'd2};
    localparam logic [NCH-1:0][31:0] NOM_FC = {32'd50, 32'd249, 32'd125, 32'd101};
    localparam logic [2:0] S_INIT = 3'd0, S_MON = 3'd1, S_FAULT = 3'd2,
                           S_RECFG = 3'd3, S_HALT = 3'd4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NCH-1:0][31:0]  fc = NOM_FC;
    logic                  cc_locked = 1'b1;
    logic                  sts_clr = 1'b0;
    logic                  recfg_ack = 1'b0;
    logic [NCH-1:0]        ch_ok;
    logic [NCH-1:0]        ch_alarm;
    logic [15:0]           lock_loss_cnt;
    logic                  recfg_req;
    logic [2:0]            state;
    logic                  halted;

    int vecs = 0;
    int errs = 0;

    // Behavioural model state (tick granularity).
    logic [NCH-1:0] m_alarm;
    int             m_lockloss;
    int             m_retries;
    int             m_run;
    int             m_good;

    clock_health_monitor #(
        .NUM_CH       (NCH),
        .TICK_CYCLES  (TICK),
        .SETTLE_TICKS (2),
        .FAIL_COUNT   (3),
        .MAX_RETRIES  (MAX_RETRIES),
        .EXP_FREQ     (EXP_P),
        .TOL          (TOL_P)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fc_q          (fc),
        .cc_locked     (cc_locked),
        .sts_clr       (sts_clr),
        .ch_ok         (ch_ok),
        .ch_alarm      (ch_alarm),
        .lock_loss_cnt (lock_loss_cnt),
        .recfg_req     (recfg_req),
        .recfg_ack     (recfg_ack),
        .state         (state),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic model_in_win(input logic [31:0] f, input int ch);
        longint a;
        longint b;
        longint d;
        a = {32'h0, f};
        b = {32'h0, EXP_P[ch]};
        d = a - b;
        if (d < 0) d = -d;
        return d <= {32'h0, TOL_P[ch]};
    endfunction

    function automatic logic [31:0] rand_fc(input int ch);
        int r;
        r = $urandom_range(0, 11);
        if (r == 0) return $urandom();
        if (r == 1) return EXP_P[ch] + TOL_P[ch] + 32'd1 + $urandom_range(0, 5);
        if (r == 2) return EXP_P[ch] - TOL_P[ch] - 32'd1 - $urandom_range(0, 5);
        return EXP_P[ch] - TOL_P[ch] + $urandom_range(0, 2 * TOL_P[ch]);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        m_alarm = '0; m_lockloss = 0; m_retries = 0; m_run = 0; m_good = 0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, output int n, output bit hit);
        hit = 1'b0;
        n = 0;
        while (n < budget && !hit) begin
            cyc(1);
            n++;
            if (state == s) hit = 1'b1;
        end
    endtask

    // Waits for MONITOR entry; INIT must last exactly two evaluation periods.
    task automatic enter_monitor();
        int n;
        bit hit;
        wait_state(S_MON, 400, n, hit);
        vecs++;
        if (!hit || n != 2 * TICK) begin
            errs++;
            $display("FAIL enter_monitor: reached=%0d after %0d cycles, required 1 after %0d", hit, n, 2 * TICK);
        end
    endtask

    // Advances one evaluation period; optional sts_clr on the evaluation cycle.
    task automatic run_tick(input bit clr);
        cyc(TICK - 1);
        sts_clr = clr;
        cyc(1);
        sts_clr = 1'b0;
    endtask

    task automatic test_reset();
        m_alarm = '0; m_lockloss = 0; m_retries = 0; m_run = 0; m_good = 0;
        rst = 1'b1;
        cyc(3);
        vecs++; if (state !== S_INIT) begin errs++; $display("FAIL reset_state: got %0d expected %0d", state, S_INIT); end
        vecs++; if (ch_ok !== 4'h0) begin errs++; $display("FAIL reset_ch_ok: got %h expected 0", ch_ok); end
        vecs++; if (ch_alarm !== 4'h0) begin errs++; $display("FAIL reset_ch_alarm: got %h expected 0", ch_alarm); end
        vecs++; if (lock_loss_cnt !== 16'd0) begin errs++; $display("FAIL reset_lock_loss: got %0d expected 0", lock_loss_cnt); end
        vecs++; if (recfg_req !== 1'b0) begin errs++; $display("FAIL reset_recfg_req: got %b expected 0", recfg_req); end
        vecs++; if (halted !== 1'b0) begin errs++; $display("FAIL reset_halted: got %b expected 0", halted); end
        $display("reset: state=%0d ch_ok=%h alarm=%h lock_loss=%0d", state, ch_ok, ch_alarm, lock_loss_cnt);
    endtask

    task automatic test_nominal();
        bit req_seen;
        rst = 1'b0;
        enter_monitor();
        req_seen = 1'b0;
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < TICK; k++) begin
                cyc(1);
                if (recfg_req) req_seen = 1'b1;
            end
            vecs++; if (ch_ok !== 4'hF) begin errs++; $display("FAIL nominal_ch_ok: got %h expected f", ch_ok); end
            vecs++; if (ch_alarm !== 4'h0) begin errs++; $display("FAIL nominal_alarm: got %h expected 0", ch_alarm); end
            vecs++; if (state !== S_MON) begin errs++; $display("FAIL nominal_state: got %0d expected %0d", state, S_MON); end
            $display("nominal tick %0d: ch_ok=%h alarm=%h state=%0d", t, ch_ok, ch_alarm, state);
        end
        vecs++; if (req_seen !== 1'b0) begin errs++; $display("FAIL nominal_no_req: got %b expected 0", req_seen); end
    endtask

    task automatic test_boundary();
        logic [31:0] bv [5];
        logic        eok [5];
        logic        eal [5];
        bv  = '{32'd98, 32'd102, 32'd103, 32'hFFFF_FFFF, 32'd100};
        eok = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        eal = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int t = 0; t < 5; t++) begin
            fc[0] = bv[t];
            run_tick(t == 0);
            vecs++; if (ch_ok[0] !== eok[t]) begin errs++; $display("FAIL boundary_ok fc0=%h: got %b expected %b", bv[t], ch_ok[0], eok[t]); end
            vecs++; if (ch_alarm[0] !== eal[t]) begin errs++; $display("FAIL boundary_alarm fc0=%h: got %b expected %b", bv[t], ch_alarm[0], eal[t]); end
            vecs++; if (state !== S_MON) begin errs++; $display("FAIL boundary_state fc0=%h: got %0d expected %0d", bv[t], state, S_MON); end
            $display("boundary fc0=%h: ch_ok0=%b alarm0=%b state=%0d", bv[t], ch_ok[0], ch_alarm[0], state);
        end
        fc = NOM_FC;
    endtask

    task automatic test_lock_loss();
        int n;
        bit hit;
        fc = NOM_FC;
        do_reset();
        enter_monitor();
        recfg_ack = 1'b1;
        cyc(3);
        recfg_ack = 1'b0;
        vecs++; if (state !== S_MON) begin errs++; $display("FAIL ack_outside_recfg: got %0d expected %0d", state, S_MON); end
        cc_locked = 1'b0;
        wait_state(S_FAULT, 8, n, hit);
        vecs++; if (!hit || n > 5) begin errs++; $display("FAIL lock_fault_latency: hit=%0d cycles=%0d required <=5", hit, n); end
        vecs++; if (lock_loss_cnt !== 16'd1) begin errs++; $display("FAIL lock_loss_first: got %0d expected 1", lock_loss_cnt); end
        $display("lock loss: fault after %0d cycles, lock_loss=%0d", n, lock_loss_cnt);
        cyc(1);
        cc_locked = 1'b1;
        vecs++; if (state !== S_RECFG) begin errs++; $display("FAIL lock_recfg: got %0d expected %0d", state, S_RECFG); end
        recfg_ack = 1'b1;
        cyc(1);
        recfg_ack = 1'b0;
        cyc(5);
        cc_locked = 1'b0;
        cyc(2);
        sts_clr = 1'b1;
        cyc(1);
        sts_clr = 1'b0;
        vecs++; if (lock_loss_cnt !== 16'd1) begin errs++; $display("FAIL lock_clr_with_edge: got %0d expected 1", lock_loss_cnt); end
        vecs++; if (state !== S_INIT) begin errs++; $display("FAIL lock_edge_in_init: got %0d expected %0d", state, S_INIT); end
        $display("clear with edge: lock_loss=%0d state=%0d", lock_loss_cnt, state);
        cc_locked = 1'b1;
        cyc(5);
        sts_clr = 1'b1;
        cyc(1);
        sts_clr = 1'b0;
        vecs++; if (lock_loss_cnt !== 16'd0) begin errs++; $display("FAIL lock_clr_only: got %0d expected 0", lock_loss_cnt); end
    endtask

    task automatic test_retry_exhaustion();
        bit req_drop;
        do_reset();
        fc = NOM_FC;
        fc[2] = 32'd0;
        enter_monitor();
        for (int r = 0; r <= MAX_RETRIES; r++) begin
            for (int t = 0; t < 3; t++) run_tick(1'b0);
            cyc(1);
            vecs++; if (state !== S_FAULT) begin errs++; $display("FAIL persist_fault %0d: got %0d expected %0d", r, state, S_FAULT); end
            cyc(1);
            if (r < MAX_RETRIES) begin
                vecs++; if (state !== S_RECFG || recfg_req !== 1'b1) begin errs++; $display("FAIL persist_recfg %0d: state=%0d req=%b expected %0d 1", r, state, recfg_req, S_RECFG); end
                req_drop = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    cyc(1);
                    if (recfg_req !== 1'b1) req_drop = 1'b1;
                end
                vecs++; if (req_drop !== 1'b0) begin errs++; $display("FAIL persist_req_hold %0d: dropped=%b expected 0", r, req_drop); end
                recfg_ack = 1'b1;
                cyc(1);
                recfg_ack = 1'b0;
                vecs++; if (state !== S_INIT || recfg_req !== 1'b0) begin errs++; $display("FAIL persist_ack %0d: state=%0d req=%b expected 0 0", r, state, recfg_req); end
                $display("retry %0d: recfg acked, state=%0d req=%b", r + 1, state, recfg_req);
                enter_monitor();
            end else begin
                vecs++; if (state !== S_HALT || halted !== 1'b1) begin errs++; $display("FAIL halt: state=%0d halted=%b expected %0d 1", state, halted, S_HALT); end
                req_drop = 1'b0;
                for (int k = 0; k < 50; k++) begin
                    cyc(1);
                    if (recfg_req !== 1'b0 || state !== S_HALT) req_drop = 1'b1;
                end
                vecs++; if (req_drop !== 1'b0) begin errs++; $display("FAIL halt_stays: disturbed=%b expected 0", req_drop); end
                $display("halt: state=%0d halted=%b req=%b", state, halted, recfg_req);
            end
        end
        fc = NOM_FC;
    endtask

    task automatic test_reset_mid_recfg();
        int n;
        bit hit;
        do_reset();
        fc = NOM_FC;
        fc[1] = 32'd0;
        enter_monitor();
        run_tick(1'b0);
        vecs++; if (ch_alarm !== 4'b0010) begin errs++; $display("FAIL rr_alarm: got %h expected 2", ch_alarm); end
        fc = NOM_FC;
        cc_locked = 1'b0;
        wait_state(S_RECFG, 10, n, hit);
        vecs++; if (!hit || recfg_req !== 1'b1) begin errs++; $display("FAIL rr_in_recfg: hit=%0d req=%b expected 1 1", hit, recfg_req); end
        rst = 1'b1;
        cyc(1);
        vecs++; if (recfg_req !== 1'b0) begin errs++; $display("FAIL rr_req: got %b expected 0", recfg_req); end
        vecs++; if (state !== S_INIT) begin errs++; $display("FAIL rr_state: got %0d expected %0d", state, S_INIT); end
        vecs++; if (ch_alarm !== 4'h0) begin errs++; $display("FAIL rr_alarm_clr: got %h expected 0", ch_alarm); end
        vecs++; if (lock_loss_cnt !== 16'd0) begin errs++; $display("FAIL rr_lock_loss: got %0d expected 0", lock_loss_cnt); end
        vecs++; if (ch_ok !== 4'h0 || halted !== 1'b0) begin errs++; $display("FAIL rr_ok_halt: ch_ok=%h halted=%b expected 0 0", ch_ok, halted); end
        $display("reset mid-recfg: state=%0d req=%b alarm=%h lock_loss=%0d", state, recfg_req, ch_alarm, lock_loss_cnt);
        rst = 1'b0;
        cc_locked = 1'b1;
        m_alarm = '0; m_lockloss = 0; m_retries = 0; m_run = 0; m_good = 0;
        enter_monitor();
    endtask

    task automatic test_random();
        logic [NCH-1:0] exp_ok;
        bit clr;
        do_reset();
        enter_monitor();
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NCH; c++) fc[c] = rand_fc(c);
            clr = ($urandom_range(0, 5) == 0);
            run_tick(clr);
            for (int c = 0; c < NCH; c++) exp_ok[c] = model_in_win(fc[c], c);
            if (clr) begin m_alarm = '0; m_lockloss = 0; end
            m_alarm = m_alarm | ~exp_ok;
            if (&exp_ok) begin
                m_run = 0;
                m_good++;
                if (m_good == 16) begin m_good = 0; m_retries = 0; end
            end else begin
                m_run++;
                m_good = 0;
            end
            $display("rand tick %0d: fc=%h clr=%0d ch_ok=%h/%h alarm=%h/%h state=%0d", t, fc, clr, ch_ok, exp_ok, ch_alarm, m_alarm, state);
            vecs++; if (ch_ok !== exp_ok) begin errs++; $display("FAIL rand_ch_ok %0d: got %h expected %h", t, ch_ok, exp_ok); end
            vecs++; if (ch_alarm !== m_alarm) begin errs++; $display("FAIL rand_alarm %0d: got %h expected %h", t, ch_alarm, m_alarm); end
            vecs++; if (lock_loss_cnt !== 16'(m_lockloss)) begin errs++; $display("FAIL rand_lock_loss %0d: got %0d expected %0d", t, lock_loss_cnt, m_lockloss); end
            vecs++; if (state !== S_MON) begin errs++; $display("FAIL rand_state %0d: got %0d expected %0d", t, state, S_MON); end
            if (m_run == 3) begin
                cyc(1);
                vecs++; if (state !== S_FAULT) begin errs++; $display("FAIL rand_fault %0d: got %0d expected %0d", t, state, S_FAULT); end
                cyc(1);
                if (m_retries == MAX_RETRIES) begin
                    vecs++; if (state !== S_HALT || halted !== 1'b1) begin errs++; $display("FAIL rand_halt %0d: state=%0d halted=%b", t, state, halted); end
                    do_reset();
                    enter_monitor();
                end else begin
                    vecs++; if (state !== S_RECFG || recfg_req !== 1'b1) begin errs++; $display("FAIL rand_recfg %0d: state=%0d req=%b", t, state, recfg_req); end
                    m_retries++;
                    cyc($urandom_range(0, 15));
                    recfg_ack = 1'b1;
                    cyc(1);
                    recfg_ack = 1'b0;
                    vecs++; if (state !== S_INIT || recfg_req !== 1'b0) begin errs++; $display("FAIL rand_ack %0d: state=%0d req=%b", t, state, recfg_req); end
                    enter_monitor();
                end
                m_run = 0;
                m_good = 0;
            end
        end
        fc = NOM_FC;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_boundary();
        test_lock_loss();
        test_retry_exhaustion();
        test_reset_mid_recfg();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
